// File: rtl/compare_pipe.sv
`default_nettype none
// ============================================================================
// Module      : compare_pipe
// Description : Two-stage valid/ready compare pipeline. Stage 1 captures the
//               operands, op and last flag. Stage 2 holds the compare result
//               and the running per-group any/all/saturating true-count.
// Revision    : 1.0 - initial release
// ============================================================================
module compare_pipe #(
   parameter int WIDTH  = 11,
   parameter int SIGNED = 1,
   parameter int CNT_W  = 8
) (
   input  logic             m_clock,
   input  logic             p_reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic [2:0]       in_op,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_result,
   output logic             out_any,
   output logic             out_all,
   output logic [CNT_W-1:0] out_count,
   output logic             out_last
);

   localparam logic [2:0]       OP_GT   = 3'd0;
   localparam logic [2:0]       OP_LT   = 3'd1;
   localparam logic [2:0]       OP_GTE  = 3'd2;
   localparam logic [2:0]       OP_LTE  = 3'd3;
   localparam logic [2:0]       OP_EQ   = 3'd4;
   localparam logic [2:0]       OP_NE   = 3'd5;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   // Stage 1 registers
   logic             s1_valid;
   logic [WIDTH-1:0] s1_a;
   logic [WIDTH-1:0] s1_b;
   logic [2:0]       s1_op;
   logic             s1_last;

   // Set when the next beat entering stage 2 opens a fresh group
   logic             new_group;

   logic              s2_load;
   logic signed [WIDTH:0] a_ext;
   logic signed [WIDTH:0] b_ext;
   logic              cmp_res;
   logic              nxt_any;
   logic              nxt_all;
   logic [CNT_W-1:0]  nxt_cnt;

   // Stage 2 takes a new beat when empty or when its current beat leaves.
   // in_ready is forced low while reset is held and rises as soon as it drops.
   assign s2_load  = ~out_valid | out_ready;
   assign in_ready = ~p_reset & (~s1_valid | s2_load);

   // Widen by one bit so one signed compare serves both signed and unsigned modes
   always_comb begin
      a_ext = {((SIGNED != 0) ? s1_a[WIDTH-1] : 1'b0), s1_a};
      b_ext = {((SIGNED != 0) ? s1_b[WIDTH-1] : 1'b0), s1_b};
   end

   // Operation decode; reserved codes produce a false result
   always_comb begin
      cmp_res = 1'b0;
      case (s1_op)
         OP_GT:   cmp_res = (a_ext >  b_ext);
         OP_LT:   cmp_res = (a_ext <  b_ext);
         OP_GTE:  cmp_res = (a_ext >= b_ext);
         OP_LTE:  cmp_res = (a_ext <= b_ext);
         OP_EQ:   cmp_res = (a_ext == b_ext);
         OP_NE:   cmp_res = (a_ext != b_ext);
         default: cmp_res = 1'b0;
      endcase
   end

   // Group accumulator next values: restart on a new group, else fold in with saturation
   always_comb begin
      nxt_any = cmp_res;
      nxt_all = cmp_res;
      nxt_cnt = CNT_W'(cmp_res);
      if (!new_group) begin
         nxt_any = out_any | cmp_res;
         nxt_all = out_all & cmp_res;
         nxt_cnt = out_count;
         if (cmp_res && (out_count != CNT_MAX)) begin
            nxt_cnt = out_count + CNT_W'(1);
         end
      end
   end

   // Stage 1: capture an accepted beat, or drain when stage 2 takes the held one
   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) begin
         s1_valid <= 1'b0;
         s1_a     <= '0;
         s1_b     <= '0;
         s1_op    <= '0;
         s1_last  <= 1'b0;
      end else if (in_ready) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_a    <= in_a;
            s1_b    <= in_b;
            s1_op   <= in_op;
            s1_last <= in_last;
         end
      end
   end

   // Stage 2: result and group state change only when a beat enters; held otherwise
   always_ff @(posedge m_clock or posedge p_reset) begin
      if (p_reset) begin
         out_valid  <= 1'b0;
         out_result <= 1'b0;
         out_any    <= 1'b0;
         out_all    <= 1'b0;
         out_count  <= '0;
         out_last   <= 1'b0;
         new_group  <= 1'b1;
      end else if (s2_load) begin
         out_valid <= s1_valid;
         if (s1_valid) begin
            out_result <= cmp_res;
            out_any    <= nxt_any;
            out_all    <= nxt_all;
            out_count  <= nxt_cnt;
            out_last   <= s1_last;
            new_group  <= s1_last;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/compare_pipe.md
COMPARE_PIPE -- requirements
Module: compare_pipe

Interface
REQ-001: Parameter WIDTH, default 11, SHALL set the operand width in bits (legal range 2..32).
REQ-002: Parameter SIGNED, default 1, SHALL select two's-complement compare when 1 and unsigned compare when 0.
REQ-003: Parameter CNT_W, default 8, SHALL set the width of the group true-count output.
REQ-004: m_clock  in  1  SHALL be the single clock; every register updates on its rising edge.
REQ-005: p_reset  in  1  SHALL be the reset, asynchronous and active-high.
REQ-006: in_valid  in  1  SHALL mark an offered operand beat.
REQ-007: in_ready  out  1  SHALL mark that the block accepts a beat this cycle.
REQ-008: in_a, in_b  in  WIDTH each  SHALL carry the operands.
REQ-009: in_op  in  3  SHALL select the operation: 0 gt, 1 lt, 2 gte, 3 lte, 4 eq, 5 ne; codes 6 and 7 are reserved.
REQ-010: in_last  in  1  SHALL mark the final beat of a group.
REQ-011: out_valid  out  1  SHALL mark a presented result beat.
REQ-012: out_ready  in  1  SHALL mark that downstream accepts the result this cycle.
REQ-013: out_result  out  1  SHALL carry the compare result of this beat.
REQ-014: out_any, out_all  out  1 each  SHALL carry the group OR and group AND of results up to and including this beat.
REQ-015: out_count  out  CNT_W  SHALL carry the group count of true results up to and including this beat.
REQ-016: out_last  out  1  SHALL carry in_last of this beat.

Function
REQ-017: A beat SHALL transfer on input when in_valid and in_ready are both 1, and on output when out_valid and out_ready are both 1.
REQ-018: The pipeline SHALL have two register stages: stage 1 holds operands, op and last; stage 2 holds the compare and group results.
REQ-019: Latency SHALL be 2 cycles from input transfer to out_valid when out_ready is held at 1.
REQ-020: Stage 2 SHALL load when it is empty or when an output transfer occurs in the same cycle.
REQ-021: in_ready SHALL equal (not stage-1 valid) or (stage 2 loads this cycle), giving one beat per cycle at full throughput.
REQ-022: While out_valid is 1 and out_ready is 0, all out_* signals SHALL hold stable.
REQ-023: Comparison SHALL use the full WIDTH with no truncation; sign handling follows SIGNED.
REQ-024: Reserved op codes SHALL yield out_result 0, and the beat SHALL still count toward the group.
REQ-025: Group accumulators (any, all, count) SHALL update only when a beat enters stage 2.
REQ-026: The first beat after reset, and the first beat after a last beat, SHALL start a new group: any = r, all = r, count = r.
REQ-027: Each later beat in a group SHALL update any |= r, all &= r, and count += r.
REQ-028: count SHALL saturate at 2^CNT_W-1 and not wrap.
REQ-029: A single-beat group (in_last = 1 on its first beat) SHALL report its own result in any, all and count.
REQ-030: The output SHALL be a strict FIFO order of accepted beats, with no drops and no duplicates under any valid/ready pattern.

Reset
REQ-031: While p_reset is 1, out_valid, out_result, out_any, out_all, out_last and stage-1 valid SHALL be 0, and out_count SHALL be 0.
REQ-032: While p_reset is 1, in_ready SHALL be 0; it SHALL go to 1 in the first cycle after reset deasserts.
REQ-033: Reset asserted mid-group SHALL discard in-flight beats and group state, and the next beat SHALL start a new group.

Verification
REQ-034: WIDTH=11, SIGNED=1, op gt, a=-1 (0x7FF), b=1 -> out_result 0; the same beat with SIGNED=0 -> out_result 1.
REQ-035: Back-to-back beats with out_ready held at 1: ops gt/lt/gte/lte/eq/ne on a=5, b=5 -> results 0,0,1,1,1,0 on six consecutive cycles, each 2 cycles after its input.
REQ-036: Group of 4 beats with results 1,0,1,1 and last on beat 4 -> beat 4 shows any=1, all=0, count=3, last=1; the next beat starts a fresh group.
REQ-037: out_ready held low for 5 cycles with in_valid high -> exactly 2 beats are accepted, then in_ready=0, outputs stay stable, and order is preserved after release.
REQ-038: CNT_W=2, 5 true beats in one group -> out_count reads 1,2,3,3,3.
REQ-039: p_reset pulse with 2 beats in flight -> out_valid=0 immediately, and the next beat's group reports count equal to its own result only.
